// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the BIST-wrapped SRAM.
// Element properties are returned as single bits; callers replicate them to word width.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4
  } bist_state_e;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  function automatic logic elem_is_down(input logic [2:0] e);
    return (e == M3) || (e == M4);
  endfunction

  // Background expected on read: B1 for M2/M4, B0 otherwise
  function automatic logic elem_exp_one(input logic [2:0] e);
    return (e == M2) || (e == M4);
  endfunction

  function automatic logic elem_wr_one(input logic [2:0] e);
    return (e == M1) || (e == M3);
  endfunction

endpackage

// File: rtl/sram_bist_march_if.sv
// Functional SRAM port plus BIST control/status, bundled for the wrapper.
interface sram_bist_march_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] dat_in;
  logic [ADDR_W-1:0] addr_in;
  logic              w_en;
  logic [DATA_W-1:0] read_d;
  logic              bist_start;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;

  modport master (
    output dat_in, addr_in, w_en, bist_start,
    input  read_d, bist_busy, bist_done, bist_fail, fail_addr, fail_elem
  );

  modport slave (
    input  dat_in, addr_in, w_en, bist_start,
    output read_d, bist_busy, bist_done, bist_fail, fail_addr, fail_elem
  );
endinterface

// File: rtl/sram_param.sv
// Single-port synchronous SRAM with registered, read-first output.
// Array contents are deliberately not reset; only the output register is.
module sram_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] read_d_d;
  logic [DATA_W-1:0] read_d_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
  end

  always_comb begin
    read_d_d = mem[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) read_d_q <= '0;
    else     read_d_q <= read_d_d;
  end

  assign rd = read_d_q;
endmodule

// File: rtl/sram_bist_march.sv
// SRAM macro plus March C- BIST controller; functional port owns the array unless busy.
//   state | meaning
//   IDLE  | functional mode, waiting for bist_start
//   WR    | M0: write B0, one address per cycle
//   RD    | issue read of current address
//   CHK   | compare read_d with expected; M1-M4 also write new background
//   DONE  | test finished, done/fail held until next start
module sram_bist_march
  import sram_bist_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst,
  sram_bist_march_if.slave bus
);
  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        elem_q, elem_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;

  logic              busy;
  logic              last;
  logic              mismatch;
  logic [2:0]        elem_nxt;
  logic [ADDR_W-1:0] addr_step;
  logic [DATA_W-1:0] exp_word;
  logic              bist_we;
  logic [DATA_W-1:0] bist_wd;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  assign busy = (state_q == ST_WR) || (state_q == ST_RD) || (state_q == ST_CHK);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    elem_d      = elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    bist_we     = 1'b0;
    bist_wd     = {DATA_W{elem_wr_one(elem_q)}};
    exp_word    = {DATA_W{elem_exp_one(elem_q)}};
    mismatch    = 1'b0;
    elem_nxt    = elem_q + 3'd1;
    last        = elem_is_down(elem_q) ? (addr_q == '0) : (addr_q == '1);
    addr_step   = elem_is_down(elem_q) ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.bist_start) begin
          state_d     = ST_WR;
          addr_d      = '0;
          elem_d      = M0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      ST_WR: begin
        bist_we = 1'b1;
        if (last) begin
          elem_d  = M1;
          addr_d  = '0;
          state_d = ST_RD;
        end else begin
          addr_d = addr_step;
        end
      end
      ST_RD: begin
        state_d = ST_CHK;
      end
      ST_CHK: begin
        mismatch = (mem_rd != exp_word);
        if (mismatch) begin
          fail_d = 1'b1;
          if (!fail_q) begin
            fail_addr_d = addr_q;
            fail_elem_d = elem_q;
          end
        end
        bist_we = (elem_q != M5);
        if (last) begin
          if (elem_q == M5) begin
            state_d = ST_DONE;
          end else begin
            elem_d  = elem_nxt;
            addr_d  = elem_is_down(elem_nxt) ? '1 : '0;
            state_d = ST_RD;
          end
        end else begin
          addr_d  = addr_step;
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      elem_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      elem_q      <= elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign mem_we   = busy ? bist_we : bus.w_en;
  assign mem_addr = busy ? addr_q  : bus.addr_in;
  assign mem_wd   = busy ? bist_wd : bus.dat_in;

  sram_param #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk (clk),
    .rst (rst),
    .we  (mem_we),
    .addr(mem_addr),
    .wd  (mem_wd),
    .rd  (mem_rd)
  );

  assign bus.read_d    = mem_rd;
  assign bus.bist_busy = busy;
  assign bus.bist_done = (state_q == ST_DONE);
  assign bus.bist_fail = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_elem = fail_elem_q;
endmodule

// File: tb/tb_sram_bist_march.sv
// Directed bench for sram_bist_march: functional SRAM, clean/faulty/aborted March runs, small-geometry run.
module tb_sram_bist_march;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sram_bist_march_if #(.DATA_W(4), .ADDR_W(8)) bus_a ();
  sram_bist_march_if #(.DATA_W(8), .ADDR_W(4)) bus_b ();

  sram_bist_march #(.DATA_W(4), .ADDR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  sram_bist_march #(.DATA_W(8), .ADDR_W(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr_a(input logic [7:0] a, input logic [3:0] d);
    @(negedge clk);
    bus_a.addr_in = a;
    bus_a.dat_in  = d;
    bus_a.w_en    = 1'b1;
    @(posedge clk);
    #1 bus_a.w_en = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [7:0] a, input logic [3:0] exp);
    @(negedge clk);
    bus_a.addr_in = a;
    @(posedge clk);
    #1 chk(tag, 32'(bus_a.read_d), 32'(exp));
  endtask

  // Counts cycles with bist_busy high; optionally flips one cell after M0 and toggles functional inputs.
  task automatic bist_a(input int inject_at, input bit toggle, output int cycles);
    @(negedge clk);
    bus_a.bist_start = 1'b1;
    @(posedge clk);
    #1 bus_a.bist_start = 1'b0;
    cycles = 0;
    while (bus_a.bist_busy && cycles < 4000) begin
      cycles++;
      if (cycles == inject_at) dut_a.u_mem.mem[8'h35] = 4'h1;
      if (toggle) begin
        bus_a.w_en    = cycles[0];
        bus_a.addr_in = cycles[7:0];
        bus_a.dat_in  = 4'hF;
      end
      @(posedge clk);
      #1;
    end
    bus_a.w_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus_a.dat_in = '0; bus_a.addr_in = '0; bus_a.w_en = 1'b0; bus_a.bist_start = 1'b0;
    bus_b.dat_in = '0; bus_b.addr_in = '0; bus_b.w_en = 1'b0; bus_b.bist_start = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_d", 32'(bus_a.read_d), 0);
    chk("rst_busy", 32'(bus_a.bist_busy), 0);
    chk("rst_done", 32'(bus_a.bist_done), 0);
    chk("rst_fail", 32'(bus_a.bist_fail), 0);
    chk("rst_fail_addr", 32'(bus_a.fail_addr), 0);
    chk("rst_fail_elem", 32'(bus_a.fail_elem), 0);
    @(negedge clk);
    rst = 1'b0;

    wr_a(8'h05, 4'h1);
    wr_a(8'h06, 4'h2);
    wr_a(8'h35, 4'h3);
    wr_a(8'h45, 4'h4);
    for (int i = 1; i <= 4; i++) wr_a(8'(i), 4'hF);
    rd_a("fn_rd_05", 8'h05, 4'h1);
    rd_a("fn_rd_06", 8'h06, 4'h2);
    rd_a("fn_rd_35", 8'h35, 4'h3);
    rd_a("fn_rd_45", 8'h45, 4'h4);
    for (int i = 1; i <= 4; i++) rd_a("fn_rd_0x", 8'(i), 4'hF);

    wr_a(8'h10, 4'h5);
    @(negedge clk);
    bus_a.addr_in = 8'h10;
    bus_a.dat_in  = 4'hA;
    bus_a.w_en    = 1'b1;
    @(posedge clk);
    #1 chk("read_first_old", 32'(bus_a.read_d), 32'h5);
    bus_a.w_en = 1'b0;
    rd_a("read_first_new", 8'h10, 4'hA);

    bist_a(-1, 1'b1, cyc);
    chk("clean_busy_cycles", 32'(cyc), 2816);
    chk("clean_done", 32'(bus_a.bist_done), 1);
    chk("clean_fail", 32'(bus_a.bist_fail), 0);
    rd_a("post_bist_rd_10", 8'h10, 4'h0);

    bist_a(300, 1'b0, cyc);
    chk("stuck_busy_cycles", 32'(cyc), 2816);
    chk("stuck_done", 32'(bus_a.bist_done), 1);
    chk("stuck_fail", 32'(bus_a.bist_fail), 1);
    chk("stuck_fail_addr", 32'(bus_a.fail_addr), 32'h35);
    chk("stuck_fail_elem", 32'(bus_a.fail_elem), 1);

    @(negedge clk);
    bus_a.bist_start = 1'b1;
    @(posedge clk);
    #1 bus_a.bist_start = 1'b0;
    chk("restart_busy", 32'(bus_a.bist_busy), 1);
    chk("restart_fail_clr", 32'(bus_a.bist_fail), 0);
    chk("restart_addr_clr", 32'(bus_a.fail_addr), 0);
    chk("restart_done_clr", 32'(bus_a.bist_done), 0);
    repeat (999) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus_a.bist_busy), 0);
    chk("abort_done", 32'(bus_a.bist_done), 0);
    chk("abort_fail", 32'(bus_a.bist_fail), 0);
    chk("abort_fail_addr", 32'(bus_a.fail_addr), 0);
    chk("abort_read_d", 32'(bus_a.read_d), 0);
    @(negedge clk);
    rst = 1'b0;

    bist_a(-1, 1'b0, cyc);
    chk("rerun_busy_cycles", 32'(cyc), 2816);
    chk("rerun_done", 32'(bus_a.bist_done), 1);
    chk("rerun_fail", 32'(bus_a.bist_fail), 0);

    @(negedge clk);
    bus_b.bist_start = 1'b1;
    @(posedge clk);
    #1 bus_b.bist_start = 1'b0;
    cyc = 0;
    while (bus_b.bist_busy && cyc < 1000) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    chk("b_busy_cycles", 32'(cyc), 176);
    chk("b_done", 32'(bus_b.bist_done), 1);
    chk("b_fail", 32'(bus_b.bist_fail), 0);
    @(negedge clk);
    bus_b.addr_in = 4'h3;
    bus_b.dat_in  = 8'hA5;
    bus_b.w_en    = 1'b1;
    @(posedge clk);
    #1 bus_b.w_en = 1'b0;
    @(negedge clk);
    bus_b.addr_in = 4'h3;
    @(posedge clk);
    #1 chk("b_fn_rd_3", 32'(bus_b.read_d), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sram_bist_march.md
# sram_bist_march

Parametrised single-port synchronous SRAM with an integrated March C- built-in self-test controller. It generalises the fixed 256x4 SRAM to DATA_W x 2^ADDR_W and adds a BIST mode that takes over the array, runs the six March C- elements, and reports pass/fail with the first failing address and element. Functional ports behave as a plain SRAM whenever BIST is idle. It sits in the design as the memory macro plus its test wrapper.

## Interface
- DATA_W, 4, word width in bits
- ADDR_W, 8, address width; DEPTH = 2^ADDR_W words
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- dat_in  in  DATA_W  functional write data
- addr_in  in  ADDR_W  functional address
- w_en  in  1  functional write enable
- read_d  out  DATA_W  registered array read data, both modes
- bist_start  in  1  start request, sampled only in IDLE
- bist_busy  out  1  high while March test runs
- bist_done  out  1  sticky completion flag
- bist_fail  out  1  sticky, high if any compare mismatched
- fail_addr  out  ADDR_W  address of first mismatch
- fail_elem  out  3  March element index (0-5) of first mismatch

## Operation
- Functional mode (not busy): write mem[addr_in] <= dat_in on edge when w_en; read_d <= mem[addr_in] every edge; simultaneous write/read of same address returns OLD data (read-first).
- Array contents are not reset. rst forces read_d=0, bist_busy=0, bist_done=0, bist_fail=0, fail_addr=0, fail_elem=0, FSM to IDLE.
- bist_start high in IDLE: clears done/fail/fail_addr/fail_elem, enters RUN at element 0. bist_start ignored when busy.
- While busy, w_en/dat_in/addr_in are ignored; array driven by controller; read_d still shows array output.
- Elements (B0 = all zeros, B1 = all ones, DATA_W wide): M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0). Up = 0..DEPTH-1, down = DEPTH-1..0.
- States: IDLE, WR (single write per address, M0 only), RD (issue read), CHK (compare read_d vs expected; for M1-M4 issue the element's write to the same address in the same cycle), DONE.
- Address counter ADDR_W bits; element ends when counter hits DEPTH-1 (up) or 0 (down); then counter reloads for next element's direction. No wrap into extra iterations.
- Mismatch in CHK: bist_fail set; fail_addr/fail_elem captured only on first mismatch. Test always runs to completion.
- DONE: bist_busy=0, bist_done=1; holds until next bist_start (returns via IDLE-equivalent start) or rst.
- rst mid-test: immediate abort to IDLE, all flags cleared, array contents undefined.

## Timing
- Functional read latency 1 cycle: address on edge N, data valid after edge N.
- M0: 1 cycle/address; M1-M5: 2 cycles/address (RD, CHK). Total busy = 11*DEPTH cycles (2816 for default).
- bist_busy rises on the edge sampling bist_start; falls and bist_done rises on the same edge, 11*DEPTH cycles later.
- fail flags update on the edge ending the CHK cycle that mismatched.

## Structure
- Package sram_bist_pkg: state enum, element index constants M0-M5, per-element direction/expected/write-value constants, background helpers.
- Sub-module sram_param (DATA_W, ADDR_W): the array with registered read-first output; instance name u_mem, storage array named mem (bench fault injection uses u_mem.mem).
- Top holds FSM, address/element counters, port mux, failure capture.

## Test plan
- Functional: write 0x1@0x05, 0x2@0x06, 0x3@0x35, 0x4@0x45, 0xF@0x01-0x04; read back -> same values, each one cycle after address.
- Read-first: w_en=1, addr 0x10, 0xA over stored 0x5 -> read_d=0x5 that cycle, 0xA on next read.
- Clean BIST (default params): pulse bist_start -> busy exactly 2816 cycles, done=1, fail=0; w_en toggling during run has no effect.
- Stuck-at: force u_mem.mem[0x35] bit0 to 1 -> fail=1, fail_addr=0x35, fail_elem=1; done still after 2816 cycles.
- Reset mid-test: assert rst at cycle 1000 of run -> busy/done/fail/fail_addr all 0 immediately; new start completes normally.
- Parametrised: DATA_W=8, ADDR_W=4 -> clean run busy 176 cycles, done=1, fail=0.
